// File: rtl/tnoc_flit_type_demux_if.sv
// Flit bus bundle for the type demux: one input lane in, CHANNELS lanes out.
interface tnoc_flit_type_demux_if #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned FLIT_WIDTH = 64
);
    logic                           i_valid;
    logic                           o_ready;
    logic [FLIT_WIDTH-1:0]          i_flit;
    logic                           i_head;
    logic                           i_tail;
    logic [CHANNELS-1:0]            o_valid;
    logic [CHANNELS-1:0]            i_ready;
    logic [CHANNELS*FLIT_WIDTH-1:0] o_flit;
    logic [CHANNELS-1:0]            o_head;
    logic [CHANNELS-1:0]            o_tail;

    // Demux side: consumes the input lane, produces the per-channel lanes.
    modport slave (
        input  i_valid, i_flit, i_head, i_tail, i_ready,
        output o_ready, o_valid, o_flit, o_head, o_tail
    );

    // Environment side: produces the input lane, consumes the per-channel lanes.
    modport master (
        output i_valid, i_flit, i_head, i_tail, i_ready,
        input  o_ready, o_valid, o_flit, o_head, o_tail
    );
endinterface

// File: rtl/tnoc_flit_type_demux.sv
// Routes flit packets to per-type output channels by the header type field;
// each channel has its own FIFO and unmatched packets are discarded.
module tnoc_flit_type_demux #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned TYPE_WIDTH = 8,
    parameter int unsigned TYPE_LSB   = 0,
    parameter logic [CHANNELS*TYPE_WIDTH-1:0] CHANNEL_TYPES = {8'h03, 8'h02, 8'h01, 8'h00},
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    tnoc_flit_type_demux_if.slave     io_bus,
    output logic [15:0]               o_drop_count,
    output logic                      o_error
);

    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FORWARD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [SEL_W-1:0]       r_sel;
    logic [SEL_W-1:0]       w_sel_nxt;

    logic [TYPE_WIDTH-1:0]  w_type;
    logic                   w_match;
    logic [SEL_W-1:0]       w_match_idx;

    logic                   w_ready;
    logic                   w_push;
    logic [SEL_W-1:0]       w_push_ch;
    logic                   w_err;
    logic                   w_drop;

    logic [15:0]            r_drop_count;
    logic                   r_error;

    logic [FLIT_WIDTH-1:0]  r_mem_flit [CHANNELS][FIFO_DEPTH];
    logic                   r_mem_head [CHANNELS][FIFO_DEPTH];
    logic                   r_mem_tail [CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr     [CHANNELS];
    logic [PTR_W-1:0]       r_rptr     [CHANNELS];
    logic [CNT_W-1:0]       r_count    [CHANNELS];

    logic [CHANNELS-1:0]    w_full;
    logic [CHANNELS-1:0]    w_empty;
    logic [CHANNELS-1:0]    w_push_vec;
    logic [CHANNELS-1:0]    w_pop_vec;

    logic [CHANNELS*FLIT_WIDTH-1:0] w_out_flit;
    logic [CHANNELS-1:0]            w_out_head;
    logic [CHANNELS-1:0]            w_out_tail;

    assign w_type = io_bus.i_flit[TYPE_LSB +: TYPE_WIDTH];

    // Type decode; the lowest-index matching channel wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (!w_match && (w_type == CHANNEL_TYPES[k*TYPE_WIDTH +: TYPE_WIDTH])) begin
                w_match     = 1'b1;
                w_match_idx = SEL_W'(k);
            end
        end
    end

    // Per-channel FIFO status and push/pop strobes.
    always_comb begin
        w_full     = '0;
        w_empty    = '0;
        w_push_vec = '0;
        w_pop_vec  = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            w_full[k]     = (r_count[k] == CNT_W'(FIFO_DEPTH));
            w_empty[k]    = (r_count[k] == '0);
            w_push_vec[k] = w_push && (w_push_ch == SEL_W'(k));
            w_pop_vec[k]  = !w_empty[k] && io_bus.i_ready[k];
        end
    end

    // FSM next state, input ready, push/drop/error strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ready     = 1'b1;
        w_push      = 1'b0;
        w_push_ch   = r_sel;
        w_err       = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.i_head) begin
                    if (w_match) begin
                        w_push_ch = w_match_idx;
                        w_ready   = !w_full[w_match_idx];
                        if (io_bus.i_valid && w_ready) begin
                            w_push = 1'b1;
                            if (!io_bus.i_tail) begin
                                w_sel_nxt   = w_match_idx;
                                w_state_nxt = ST_FORWARD;
                            end
                        end
                    end else if (io_bus.i_valid) begin
                        w_drop = 1'b1;
                        if (!io_bus.i_tail) begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end else if (io_bus.i_valid) begin
                    w_err = 1'b1;
                end
            end
            ST_FORWARD: begin
                w_ready = !w_full[r_sel];
                if (io_bus.i_valid && w_ready) begin
                    w_push = 1'b1;
                    w_err  = io_bus.i_head;
                    if (io_bus.i_tail) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (io_bus.i_valid && io_bus.i_tail) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM, error pulse and saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_error      <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_error <= w_err;
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the entry is not valid.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (w_push_vec[k]) begin
                r_mem_flit[k][r_wptr[k]] <= io_bus.i_flit;
                r_mem_head[k][r_wptr[k]] <= io_bus.i_head;
                r_mem_tail[k][r_wptr[k]] <= io_bus.i_tail;
            end
        end
    end

    // FIFO pointers and occupancy; a push is never issued into a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
                r_count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (w_push_vec[k]) begin
                    r_wptr[k] <= r_wptr[k] + PTR_W'(1);
                end
                if (w_pop_vec[k]) begin
                    r_rptr[k] <= r_rptr[k] + PTR_W'(1);
                end
                case ({w_push_vec[k], w_pop_vec[k]})
                    2'b10:   r_count[k] <= r_count[k] + CNT_W'(1);
                    2'b01:   r_count[k] <= r_count[k] - CNT_W'(1);
                    default: r_count[k] <= r_count[k];
                endcase
            end
        end
    end

    // Present each FIFO head entry on its channel slice.
    always_comb begin
        w_out_flit = '0;
        w_out_head = '0;
        w_out_tail = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            w_out_flit[k*FLIT_WIDTH +: FLIT_WIDTH] = r_mem_flit[k][r_rptr[k]];
            w_out_head[k]                          = r_mem_head[k][r_rptr[k]];
            w_out_tail[k]                          = r_mem_tail[k][r_rptr[k]];
        end
    end

    assign io_bus.o_ready  = w_ready;
    assign io_bus.o_valid  = ~w_empty;
    assign io_bus.o_flit   = w_out_flit;
    assign io_bus.o_head   = w_out_head;
    assign io_bus.o_tail   = w_out_tail;
    assign o_drop_count    = r_drop_count;
    assign o_error         = r_error;

endmodule
